// File: rtl/uart_rx_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks: receiver FSM state encoding,
// oversampling ratio, frame data width, the tick indices at which the
// receiver samples the line, and a helper that sizes the baud divider
// counter.
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    // Tick index in the middle of the start bit and at the end of a full bit
    // period; both measured on the 4-bit oversampling counter.
    localparam logic [3:0] MID_IDX  = 4'd7;
    localparam logic [3:0] END_IDX  = 4'd15;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    // Bits needed to hold div-1; never less than one bit.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ----------------------------------------------------------------------------
// uart_rx_if
// Groups the serial line, the FIFO-full feedback and the received-byte
// outputs of the UART receiver.
//   rx        : asynchronous serial input, idles high
//   fifo_full : downstream FIFO full flag, only used for overrun detection
//   rx_data   : last correctly received byte
//   rx_done   : one-cycle strobe, rx_data valid in the same cycle
//   frame_err : one-cycle strobe when the stop bit samples low
//   overrun   : one-cycle strobe when rx_done fires while fifo_full is set
// Modport slave is taken by the receiver, master by whatever drives the line
// and consumes the bytes.
// ----------------------------------------------------------------------------
interface uart_rx_if;

    logic       rx;
    logic       fifo_full;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       overrun;

    modport slave (
        input  rx,
        input  fifo_full,
        output rx_data,
        output rx_done,
        output frame_err,
        output overrun
    );

    modport master (
        output rx,
        output fifo_full,
        input  rx_data,
        input  rx_done,
        input  frame_err,
        input  overrun
    );

endinterface

// File: rtl/uart_rx_baud_tick_gen.sv
// ----------------------------------------------------------------------------
// baud_tick_gen
// Free-running divider producing a one-clock tick at OVERSAMPLE times the
// baud rate. The counter runs 0..DIV-1 with DIV = CLK_FREQ / (BAUD*16) and
// the tick is asserted while the count sits at DIV-1.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   tick : oversampling strobe, one clk wide
// ----------------------------------------------------------------------------
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int             DIV  = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int             CW   = cnt_width(DIV);
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Tick on the terminal count and wrap back to zero on the same cycle.
    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    // Divider count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with 16x oversampling. The rx pin is passed through a
// two-flop synchronizer, a falling edge on the synchronized line starts a
// frame, the start bit is re-checked mid-bit, eight data bits are sampled
// LSB first and the stop bit decides between a good byte and a framing
// error.
//   clk : system clock
//   rst : asynchronous active-high reset, aborts any frame in progress
//   bus : uart_rx_if.slave carrying rx, fifo_full, rx_data, rx_done,
//         frame_err and overrun
// ----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic        clk,
    input  logic        rst,
    uart_rx_if.slave    bus
);

    logic tick;

    baud_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Synchronizer and edge-detect flops reset high so that leaving reset
    // on an idle line never looks like a start edge.
    logic sync1_q;
    logic rx_s;
    logic rx_prev_q;
    logic start_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= bus.rx;
            rx_s      <= sync1_q;
            rx_prev_q <= rx_s;
        end
    end

    assign start_edge = rx_prev_q & ~rx_s;

    state_e     state_q,     state_d;
    logic [3:0] tick_cnt_q,  tick_cnt_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [7:0] shreg_q,     shreg_d;
    logic [7:0] rx_data_q,   rx_data_d;
    logic       rx_done_q,   rx_done_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q,   overrun_d;

    // Next-state and datapath logic. Counters only move on a tick, except
    // the clear of tick_cnt when a start edge is seen in IDLE. Start edges
    // outside IDLE are ignored, so a frame ends in IDLE and re-arms there.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                end
            end

            START: begin
                if (tick) begin
                    if (tick_cnt_q == MID_IDX) begin
                        tick_cnt_d = '0;
                        if (!rx_s) begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                        end else begin
                            // Line went back high: treat as a glitch.
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (tick_cnt_q == END_IDX) begin
                        shreg_d    = {rx_s, shreg_q[7:1]};
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    if (tick_cnt_q == END_IDX) begin
                        tick_cnt_d = '0;
                        state_d    = IDLE;
                        if (rx_s) begin
                            rx_data_d = shreg_q;
                            rx_done_d = 1'b1;
                            overrun_d = bus.fifo_full;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, shift register and registered output strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= 8'h00;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_done   = rx_done_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that deserializes 8N1 UART frames from the asynchronous `rx` pin and presents each byte with a one-cycle strobe. It sits directly upstream of the 16-entry receive FIFO. `rx_done` drives the FIFO `push` and `rx_data` drives `push_data`. It contains its own 16x-oversampling baud tick generator, a two-flop input synchronizer, and flags framing errors and FIFO-overrun events.

## Interface
Parameters:
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- Derived constant `DIV = CLK_FREQ / (BAUD*16)`, integer division. 100 MHz / 9600 gives 651.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `rx`  in  1: asynchronous serial input; idles high.
- `fifo_full`  in  1: FIFO `full`, used only for overrun detection.
- `rx_data`  out  8: last correctly received byte, held until the next one.
- `rx_done`  out  1: one-cycle strobe; `rx_data` is valid in the same cycle.
- `frame_err`  out  1: one-cycle strobe when the stop bit samples low.
- `overrun`  out  1: one-cycle strobe when `rx_done` fires while `fifo_full`=1.

## Operation
- Reset values: `rx_data`=8'h00, `rx_done`=0, `frame_err`=0, `overrun`=0, state=IDLE, all counters 0. Both synchronizer flops and the edge-detect flop reset to 1.
- Tick generator:
  - Free-running counter over 0..DIV-1.
  - `tick` is high for one clk when the count is DIV-1, then the counter wraps to 0.
  - The counter width is the bit count needed to hold DIV-1.
- `rx_s` is `rx` after two flops. The start edge is `rx_s`=0 while the previous `rx_s`=1.
- FSM states:
  - IDLE → START on a start edge; clear `tick_cnt`.
  - START: `tick_cnt` counts ticks. When a tick arrives at `tick_cnt`=7 (mid start bit):
    - if `rx_s`=0: go to DATA, clear `tick_cnt` and `bit_cnt`;
    - otherwise it is a glitch: go to IDLE with no flag.
  - DATA: when a tick arrives at `tick_cnt`=15:
    - shift LSB-first, `shreg` = {`rx_s`, `shreg`[7:1]};
    - clear `tick_cnt` and increment `bit_cnt`;
    - after the 8th sample (`bit_cnt`=7) go to STOP.
  - STOP: when a tick arrives at `tick_cnt`=15:
    - if `rx_s`=1: `rx_data`←`shreg`, pulse `rx_done`, and pulse `overrun` if `fifo_full`;
    - if `rx_s`=0: pulse `frame_err`, leave `rx_data` unchanged, no `rx_done`;
    - either way go to IDLE.
- `tick_cnt` is 4 bits and `bit_cnt` is 3 bits; both change only on `tick`.
- A held-low line (break) produces exactly one `frame_err`. The next frame requires `rx` to return high and then fall again.
- A start edge during START, DATA or STOP is ignored.
- `rst` mid-frame aborts immediately. The partial byte is discarded and no strobes fire.
- A stop-bit sample that coincides with a new falling edge is handled in STOP. Re-arm happens in IDLE on the next edge only.

## Timing
- Sample points are 8, 24, 40, …, 152 ticks after the start edge is detected. Data bit n is sampled at 8+16(n+1) ticks; the stop bit at 152 ticks.
- Start-detection latency is 2–3 clk (synchronizer plus edge flop). Sample jitter is up to one tick period.
- `rx_done` rises at roughly 9.5 bit-times plus 3 clk after the falling edge at the pin, and lasts exactly 1 clk.
- Back-to-back frames with a single-bit stop are received without loss. IDLE is re-entered half a bit before the next start bit.

## Structure
- Shared package `uart_pkg`:
  - state encoding (IDLE, START, DATA, STOP, 2 bits);
  - `OVERSAMPLE`=16;
  - `DATA_BITS`=8;
  - mid-sample index 7 and end index 15.
- Sub-module `baud_tick_gen`, parameterised by `CLK_FREQ` and `BAUD`, port `tick`. The TX side reuses it.
- Synchronizer, FSM and datapath stay in `uart_rx`.

## Test plan
Bench parameters: `CLK_FREQ`=1_600_000, `BAUD`=10_000, so DIV=10 and 1 bit = 160 clk.
- Reset, `rx`=1 for 2000 clk → all outputs 0 and no strobes.
- Send 8'hA5 (8N1) → exactly one `rx_done`, with `rx_data`=8'hA5 and `frame_err`=0, about 1520 clk after the start edge.
- Send 8'h00, 8'hFF, 8'h3C back-to-back with no idle gap → three `rx_done` strobes in order with matching data.
- Send 8'h55 with the stop bit forced low → one `frame_err`, no `rx_done`, `rx_data` keeps its previous value.
- Low glitch of 40 clk on an idle line → no strobes and FSM back in IDLE.
- Send 8'h81 with `fifo_full`=1 → `rx_done` and `overrun` in the same cycle.
- Assert `rst` mid-frame, then send 8'h12 → the aborted frame produces nothing and the second frame yields `rx_data`=8'h12.
